// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg                                                            |
// | Shared types for the processor-memory port arbiter.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  localparam int NUM_MEM_TAGS_DEFAULT = 16;
  localparam int MEM_TAG_W            = 4;

  typedef logic [31:0]          ADDR;
  typedef logic [31:0]          DATA;
  typedef logic [MEM_TAG_W-1:0] MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    OWN_FREE    = 2'h0,
    OWN_IF      = 2'h1,
    OWN_DC      = 2'h2,
    OWN_IF_DEAD = 2'h3
  } MEM_OWNER;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_if                                                             |
// | Fetch, dcache and memory-side signals of the memory port arbiter.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // fetch side
  logic       if_req;
  ADDR        if_addr;
  logic       if_squash;
  logic       if_grant;
  MEM_TAG     if_tag;
  logic       if_data_valid;
  MEM_TAG     if_data_tag;
  DATA        if_data;

  // dcache side
  logic       dc_req;
  MEM_COMMAND dc_cmd;
  ADDR        dc_addr;
  DATA        dc_wdata;
  logic       dc_grant;
  MEM_TAG     dc_tag;
  logic       dc_data_valid;
  MEM_TAG     dc_data_tag;
  DATA        dc_data;

  // memory side
  MEM_COMMAND mem_command;
  ADDR        mem_addr;
  DATA        mem_wdata;
  MEM_TAG     mem_transaction_tag;
  MEM_TAG     mem_data_tag;
  DATA        mem_data;

  modport slave (
    input  if_req, if_addr, if_squash,
    output if_grant, if_tag, if_data_valid, if_data_tag, if_data,
    input  dc_req, dc_cmd, dc_addr, dc_wdata,
    output dc_grant, dc_tag, dc_data_valid, dc_data_tag, dc_data,
    output mem_command, mem_addr, mem_wdata,
    input  mem_transaction_tag, mem_data_tag, mem_data
  );

  modport master (
    output if_req, if_addr, if_squash,
    input  if_grant, if_tag, if_data_valid, if_data_tag, if_data,
    output dc_req, dc_cmd, dc_addr, dc_wdata,
    input  dc_grant, dc_tag, dc_data_valid, dc_data_tag, dc_data,
    input  mem_command, mem_addr, mem_wdata,
    output mem_transaction_tag, mem_data_tag, mem_data
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_owner_table.sv
// +----------------------------------------------------------------------------+
// | mem_owner_table                                                            |
// | Per-tag owner record for outstanding memory transactions.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_owner_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MEM_TAGS = NUM_MEM_TAGS_DEFAULT
) (
  input  wire logic     clock,
  input  wire logic     reset,
  input  wire logic     wr_en,
  input  MEM_TAG        wr_tag,
  input  MEM_OWNER      wr_owner,
  input  wire logic     free_en,
  input  MEM_TAG        free_tag,
  input  wire logic     squash,
  input  MEM_TAG        rd_tag,
  output MEM_OWNER      rd_owner
);

  MEM_OWNER owner_q [NUM_MEM_TAGS];
  MEM_OWNER owner_d [NUM_MEM_TAGS];

  assign rd_owner = owner_q[rd_tag];

  // Order matters: free, then squash, then write, so a reused tag keeps its new owner.
  always_comb begin
    owner_d = owner_q;
    for (int i = 1; i < NUM_MEM_TAGS; i++) begin
      if (free_en && free_tag == MEM_TAG'(i)) owner_d[i] = OWN_FREE;
      if (squash && owner_d[i] == OWN_IF)     owner_d[i] = OWN_IF_DEAD;
      if (wr_en && wr_tag == MEM_TAG'(i))     owner_d[i] = wr_owner;
    end
    owner_d[0] = OWN_FREE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) owner_q[i] <= OWN_FREE;
    end else begin
      owner_q <= owner_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Shares the memory port between fetch and dcache and routes responses.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MEM_TAGS = NUM_MEM_TAGS_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic    clock,
  input  wire logic    reset,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic             sel_if;
  logic             sel_dc;
  logic             accepted;
  logic             if_grant;
  logic             dc_grant;
  logic             wr_en;
  MEM_OWNER         wr_owner;
  logic             resp_valid;
  MEM_OWNER         rd_owner;

  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  logic             if_data_valid_d, if_data_valid_q;
  MEM_TAG           if_data_tag_d, if_data_tag_q;
  DATA              if_data_d, if_data_q;
  logic             dc_data_valid_d, dc_data_valid_q;
  MEM_TAG           dc_data_tag_d, dc_data_tag_q;
  DATA              dc_data_d, dc_data_q;

  always_comb begin
    sel_if   = bus.if_req && ((starve_cnt_q == STARVE_MAX) || !bus.dc_req);
    sel_dc   = bus.dc_req && !sel_if;
    accepted = (bus.mem_transaction_tag != '0);
    if_grant = sel_if && accepted;
    dc_grant = sel_dc && accepted;

    bus.mem_command = MEM_NONE;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    if (sel_if) begin
      bus.mem_command = MEM_LOAD;
      bus.mem_addr    = bus.if_addr;
    end else if (sel_dc) begin
      bus.mem_command = bus.dc_cmd;
      bus.mem_addr    = bus.dc_addr;
      bus.mem_wdata   = bus.dc_wdata;
    end

    // Stores get no response, so they never occupy a tag entry.
    wr_en    = if_grant || (dc_grant && bus.dc_cmd == MEM_LOAD);
    wr_owner = OWN_DC;
    if (sel_if) wr_owner = bus.if_squash ? OWN_IF_DEAD : OWN_IF;
  end

  assign bus.if_grant = if_grant;
  assign bus.dc_grant = dc_grant;
  assign bus.if_tag   = if_grant ? bus.mem_transaction_tag : '0;
  assign bus.dc_tag   = dc_grant ? bus.mem_transaction_tag : '0;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_grant) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // A squash in the response cycle kills a fetch response that is still live.
  always_comb begin
    resp_valid      = (bus.mem_data_tag != '0);
    if_data_valid_d = resp_valid && (rd_owner == OWN_IF) && !bus.if_squash;
    dc_data_valid_d = resp_valid && (rd_owner == OWN_DC);
    if_data_tag_d   = if_data_valid_d ? bus.mem_data_tag : '0;
    if_data_d       = if_data_valid_d ? bus.mem_data     : '0;
    dc_data_tag_d   = dc_data_valid_d ? bus.mem_data_tag : '0;
    dc_data_d       = dc_data_valid_d ? bus.mem_data     : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_q    <= '0;
      if_data_valid_q <= 1'b0;
      if_data_tag_q   <= '0;
      if_data_q       <= '0;
      dc_data_valid_q <= 1'b0;
      dc_data_tag_q   <= '0;
      dc_data_q       <= '0;
    end else begin
      starve_cnt_q    <= starve_cnt_d;
      if_data_valid_q <= if_data_valid_d;
      if_data_tag_q   <= if_data_tag_d;
      if_data_q       <= if_data_d;
      dc_data_valid_q <= dc_data_valid_d;
      dc_data_tag_q   <= dc_data_tag_d;
      dc_data_q       <= dc_data_d;
    end
  end

  assign bus.if_data_valid = if_data_valid_q;
  assign bus.if_data_tag   = if_data_tag_q;
  assign bus.if_data       = if_data_q;
  assign bus.dc_data_valid = dc_data_valid_q;
  assign bus.dc_data_tag   = dc_data_tag_q;
  assign bus.dc_data       = dc_data_q;

  mem_owner_table #(
    .NUM_MEM_TAGS (NUM_MEM_TAGS)
  ) u_owner_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_tag   (bus.mem_transaction_tag),
    .wr_owner (wr_owner),
    .free_en  (resp_valid),
    .free_tag (bus.mem_data_tag),
    .squash   (bus.if_squash),
    .rd_tag   (bus.mem_data_tag),
    .rd_owner (rd_owner)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed self-checking bench for mem_arbiter.                              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .NUM_MEM_TAGS (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.if_req              = 1'b0;
    bus.if_addr             = '0;
    bus.if_squash           = 1'b0;
    bus.dc_req              = 1'b0;
    bus.dc_cmd              = MEM_NONE;
    bus.dc_addr             = '0;
    bus.dc_wdata            = '0;
    bus.mem_transaction_tag = '0;
    bus.mem_data_tag        = '0;
    bus.mem_data            = '0;
  endtask

  task automatic test_reset();
    logic [127:0] got, exp;
    reset = 1'b0;
    idle();
    bus.mem_data_tag = 4'd5;
    bus.mem_data     = 32'hFFFF;
    #1;
    got = {bus.mem_command, bus.mem_addr, bus.mem_wdata, bus.if_grant, bus.dc_grant, bus.if_tag, bus.dc_tag};
    exp = {MEM_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_idle_bus: got %h expected %h", got, exp); end
    step();
    step();
    got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid, bus.dc_data_tag, bus.dc_data};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
    reset = 1'b1;
    idle();
    step();
  endtask

  task automatic test_fetch_basic();
    logic [127:0] got, exp;
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_transaction_tag = 4'd3;
    #1;
    got = {bus.if_grant, bus.if_tag, bus.dc_grant, bus.mem_command, bus.mem_addr};
    exp = {1'b1, 4'd3, 1'b0, MEM_LOAD, 32'h100};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fetch_grant: got %h expected %h", got, exp); end
    step();
    idle();
    bus.mem_data_tag = 4'd3; bus.mem_data = 32'hDEADBEEF;
    #1;
    got = {127'd0, bus.if_data_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fetch_resp_early: got %h expected %h", got, exp); end
    step();
    got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid};
    exp = {1'b1, 4'd3, 32'hDEADBEEF, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fetch_resp: got %h expected %h", got, exp); end
    idle();
    bus.mem_data_tag = 4'd3; bus.mem_data = 32'h1111;
    step();
    got = {bus.if_data_valid, bus.dc_data_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fetch_pulse_freed: got %h expected %h", got, exp); end
    idle();
  endtask

  task automatic test_starvation();
    logic [127:0] got, exp;
    idle();
    bus.dc_req = 1'b1; bus.dc_cmd = MEM_LOAD; bus.dc_addr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    for (int c = 1; c <= 4; c++) begin
      bus.mem_transaction_tag = 4'd5;
      #1;
      got = {bus.dc_grant, bus.dc_tag, bus.if_grant, bus.if_tag, bus.mem_addr};
      exp = {1'b1, 4'd5, 1'b0, 4'd0, 32'h200};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL starve_dc_wins c%0d: got %h expected %h", c, got, exp); end
      step();
    end
    bus.mem_transaction_tag = 4'd11;
    #1;
    got = {bus.if_grant, bus.if_tag, bus.dc_grant, bus.dc_tag, bus.mem_addr};
    exp = {1'b1, 4'd11, 1'b0, 4'd0, 32'h300};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL starve_fetch_wins: got %h expected %h", got, exp); end
    step();
    bus.mem_transaction_tag = 4'd5;
    #1;
    got = {bus.dc_grant, bus.if_grant};
    exp = {1'b1, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL starve_cleared: got %h expected %h", got, exp); end
    step();
    idle();
    bus.mem_data_tag = 4'd5; bus.mem_data = 32'hA5A5;
    step();
    got = {bus.dc_data_valid, bus.dc_data_tag, bus.dc_data, bus.if_data_valid};
    exp = {1'b1, 4'd5, 32'hA5A5, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL dc_resp: got %h expected %h", got, exp); end
    idle();
    bus.mem_data_tag = 4'd11; bus.mem_data = 32'h5A5A;
    step();
    got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid};
    exp = {1'b1, 4'd11, 32'h5A5A, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL starved_fetch_resp: got %h expected %h", got, exp); end
    idle();
  endtask

  task automatic test_store();
    logic [127:0] got, exp;
    idle();
    bus.dc_req = 1'b1; bus.dc_cmd = MEM_STORE; bus.dc_addr = 32'h400;
    bus.dc_wdata = 32'h12345678; bus.mem_transaction_tag = 4'd7;
    #1;
    got = {bus.dc_grant, bus.dc_tag, bus.mem_command, bus.mem_addr, bus.mem_wdata};
    exp = {1'b1, 4'd7, MEM_STORE, 32'h400, 32'h12345678};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL store_grant: got %h expected %h", got, exp); end
    step();
    idle();
    bus.mem_data_tag = 4'd7; bus.mem_data = 32'h77;
    step();
    got = {bus.dc_data_valid, bus.if_data_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL store_no_resp: got %h expected %h", got, exp); end
    idle();
  endtask

  task automatic test_squash();
    logic [127:0] got, exp;
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h500; bus.mem_transaction_tag = 4'd2;
    step();
    bus.if_addr = 32'h540; bus.mem_transaction_tag = 4'd4;
    #1;
    got = {bus.if_grant, bus.if_tag};
    exp = {1'b1, 4'd4};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL squash_setup_grant: got %h expected %h", got, exp); end
    step();
    idle();
    bus.dc_req = 1'b1; bus.dc_cmd = MEM_LOAD; bus.dc_addr = 32'h600; bus.mem_transaction_tag = 4'd6;
    step();
    idle();
    bus.if_squash = 1'b1; bus.mem_data_tag = 4'd6; bus.mem_data = 32'h66;
    step();
    got = {bus.dc_data_valid, bus.dc_data_tag, bus.dc_data, bus.if_data_valid};
    exp = {1'b1, 4'd6, 32'h66, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL squash_dc_kept: got %h expected %h", got, exp); end
    for (int k = 0; k < 2; k++) begin
      idle();
      bus.mem_data_tag = (k == 0) ? 4'd2 : 4'd4;
      bus.mem_data     = 32'h22;
      step();
      got = {bus.if_data_valid, bus.dc_data_valid};
      exp = '0;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL squash_dead_drop k%0d: got %h expected %h", k, got, exp); end
    end
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h700; bus.mem_transaction_tag = 4'd12; bus.if_squash = 1'b1;
    #1;
    got = {bus.if_grant, bus.if_tag};
    exp = {1'b1, 4'd12};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL squash_cycle_grant: got %h expected %h", got, exp); end
    step();
    idle();
    bus.mem_data_tag = 4'd12; bus.mem_data = 32'hCC;
    step();
    got = {127'd0, bus.if_data_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL squash_grant_dead: got %h expected %h", got, exp); end
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h740; bus.mem_transaction_tag = 4'd13;
    step();
    idle();
    bus.if_squash = 1'b1; bus.mem_data_tag = 4'd13; bus.mem_data = 32'hDD;
    step();
    got = {127'd0, bus.if_data_valid};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL squash_with_resp: got %h expected %h", got, exp); end
    idle();
  endtask

  task automatic test_no_accept_reuse();
    logic [127:0] got, exp;
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h900; bus.mem_transaction_tag = 4'd0;
    #1;
    got = {bus.if_grant, bus.if_tag, bus.mem_command, bus.mem_addr};
    exp = {1'b0, 4'd0, MEM_LOAD, 32'h900};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL no_accept: got %h expected %h", got, exp); end
    step();
    bus.mem_transaction_tag = 4'd9;
    step();
    idle();
    bus.mem_data_tag = 4'd9; bus.mem_data = 32'h99;
    bus.dc_req = 1'b1; bus.dc_cmd = MEM_LOAD; bus.dc_addr = 32'h980; bus.mem_transaction_tag = 4'd9;
    #1;
    got = {bus.dc_grant, bus.dc_tag};
    exp = {1'b1, 4'd9};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reuse_grant: got %h expected %h", got, exp); end
    step();
    got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid};
    exp = {1'b1, 4'd9, 32'h99, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reuse_old_owner: got %h expected %h", got, exp); end
    idle();
    bus.mem_data_tag = 4'd9; bus.mem_data = 32'h9A;
    step();
    got = {bus.dc_data_valid, bus.dc_data_tag, bus.dc_data, bus.if_data_valid};
    exp = {1'b1, 4'd9, 32'h9A, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reuse_new_owner: got %h expected %h", got, exp); end
    idle();
  endtask

  task automatic test_reset_flush();
    logic [127:0] got, exp;
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'hA00; bus.mem_transaction_tag = 4'd1;
    step();
    bus.mem_transaction_tag = 4'd14;
    step();
    idle();
    bus.dc_req = 1'b1; bus.dc_cmd = MEM_LOAD; bus.dc_addr = 32'hA80; bus.mem_transaction_tag = 4'd15;
    step();
    idle();
    reset = 1'b0;
    bus.if_squash = 1'b1; bus.mem_data_tag = 4'd1; bus.mem_data = 32'h11;
    bus.if_req = 1'b1; bus.if_addr = 32'hB00; bus.mem_transaction_tag = 4'd3;
    #1;
    got = {bus.if_grant, bus.if_tag, bus.mem_addr};
    exp = {1'b1, 4'd3, 32'hB00};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_comb_grant: got %h expected %h", got, exp); end
    step();
    got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid, bus.dc_data_tag, bus.dc_data};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_flush_out: got %h expected %h", got, exp); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      case (k)
        0: bus.mem_data_tag = 4'd14;
        1: bus.mem_data_tag = 4'd15;
        2: bus.mem_data_tag = 4'd3;
        default: bus.mem_data_tag = 4'd1;
      endcase
      bus.mem_data = 32'hBAD0 + 32'(k);
      step();
      got = {bus.if_data_valid, bus.if_data_tag, bus.if_data, bus.dc_data_valid, bus.dc_data_tag, bus.dc_data};
      exp = '0;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_flush_resp k%0d: got %h expected %h", k, got, exp); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_store();
    test_squash();
    test_no_accept_reuse();
    test_reset_flush();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single processor–memory port between the instruction fetch stage and the data cache. Each cycle it forwards at most one command to memory and records which requester owns each returned transaction tag. It routes tagged response data back to the owner, and discards responses for fetch transactions killed by a branch squash. It sits between `fetch`/`dcache` and the memory model.

## Interface
Parameters:
- `NUM_MEM_TAGS`, default `` `NUM_MEM_TAGS `` (16): memory tag space; tag 0 means "none".
- `STARVE_LIMIT`, default 4: consecutive denied fetch-request cycles before fetch gets priority.

Ports:
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch requests a load this cycle.
- `if_addr`  in  ADDR  fetch block address.
- `if_squash`  in  1  branch redirect; all in-flight fetch transactions become dead.
- `if_grant`  out  1  fetch command accepted by memory this cycle (combinational).
- `if_tag`  out  MEM_TAG  tag assigned to the fetch command; valid with `if_grant`, else 0.
- `if_data_valid`  out  1  registered response for fetch.
- `if_data_tag`  out  MEM_TAG  tag of that response.
- `if_data`  out  DATA  response data.
- `dc_req`  in  1  dcache requests this cycle.
- `dc_cmd`  in  MEM_COMMAND  MEM_LOAD or MEM_STORE.
- `dc_addr`  in  ADDR  dcache address.
- `dc_wdata`  in  DATA  store data.
- `dc_grant`, `dc_tag`, `dc_data_valid`, `dc_data_tag`, `dc_data`  out  as the fetch equivalents.
- `mem_command`  out  MEM_COMMAND  MEM_NONE when idle.
- `mem_addr`  out  ADDR.
- `mem_wdata`  out  DATA.
- `mem_transaction_tag`  in  MEM_TAG  nonzero means the command was accepted this cycle.
- `mem_data_tag`  in  MEM_TAG  nonzero means `mem_data` is valid for that tag.
- `mem_data`  in  DATA.

## Operation
- Owner table: `NUM_MEM_TAGS` entries of type MEM_OWNER, one of {OWN_FREE, OWN_IF, OWN_DC, OWN_IF_DEAD}. Entry 0 is never written.
- Selection (combinational):
  - If `starve_cnt == STARVE_LIMIT` and `if_req`, fetch wins.
  - Otherwise dcache wins if `dc_req`, then fetch.
  - The winner's cmd/addr/wdata drive `mem_*`. With no request: MEM_NONE, addr 0, wdata 0.
- Grant: `*_grant = selected && mem_transaction_tag != 0`. The loser's grant is 0. A rejected request must be re-presented by the requester.
- On a load grant, the tag's entry is written OWN_IF or OWN_DC. On a dcache store grant, the table is not written; the store has no response.
- `starve_cnt` (saturating at `STARVE_LIMIT`):
  - Increments on cycles with `if_req && !if_grant`.
  - Clears on `if_grant` or `!if_req`.
- Response with `mem_data_tag != 0`, by entry owner:
  - OWN_IF: next cycle `if_data_valid=1`, with tag and data registered; entry freed.
  - OWN_DC: same on the `dc_*` outputs; entry freed.
  - OWN_IF_DEAD: discarded; entry freed.
  - OWN_FREE: ignored; no output.
- `if_squash`: every OWN_IF entry becomes OWN_IF_DEAD at the clock edge. `if_grant` remains legal during the squash cycle.

## Timing
- Reset (`reset==0` at posedge): all entries OWN_FREE, `starve_cnt=0`, all `*_data_valid/_tag/_data` outputs 0. Combinational outputs follow their inputs even during reset; the table is not written during reset.
- Grant latency: 0 cycles, same cycle as the request. Response latency: mem_data arrival to `*_data_valid` is 1 cycle. `*_data_valid` is a single-cycle pulse.
- Simultaneous events:
  - Response and new grant on the same tag in one cycle: the new owner is written (tag reuse), and the old owner's response is still forwarded.
  - `if_squash` with a fetch grant in the same cycle: the new entry is written OWN_IF_DEAD.
  - `if_squash` with a response for an OWN_IF tag in the same cycle: the response is dropped (`if_data_valid=0`).
  - `if_squash` and `reset` together: reset wins.
- `if_squash` never affects OWN_DC entries or `dc_*` outputs.

## Structure
- Add `MEM_OWNER` enum to `sys_defs.svh`. Reuse the existing ADDR, DATA, MEM_TAG, and MEM_COMMAND types.
- One sub-module, `mem_owner_table`:
  - Write port: tag and owner.
  - Free port: tag.
  - Squash input.
  - Combinational read port: owner of `mem_data_tag`.
- Selection, starvation counter, and response registers live in `mem_arbiter`.

## Test plan
- Reset, then `if_req` alone at addr 0x100, mem tag 3: `if_grant=1`, `if_tag=3`, `mem_addr=0x100`. Tag 3 returns 0xDEADBEEF → `if_data_valid=1`, tag 3, data 0xDEADBEEF one cycle later.
- `dc_req` load and `if_req` together, mem tag 5: `dc_grant=1`, `if_grant=0`. Hold both for 4 cycles with tags accepted → cycle 5 grants fetch. `starve_cnt` returns to 0.
- Dcache store, tag 7, then `mem_data_tag=7`: no `dc_data_valid`, no `if_data_valid`.
- Fetch tags 2 and 4 outstanding, pulse `if_squash`, return both: no `if_data_valid`. A dcache tag 6 returned the same cycle is still delivered.
- `mem_transaction_tag=0` with `if_req`: `if_grant=0`, `if_tag=0`, table unchanged. Tag 9 returns and is regranted to dcache in the same cycle → old owner forwarded, entry 9 = OWN_DC.
- Drive `reset` low with 3 entries outstanding: all responses afterward are ignored, and outputs are 0.
